// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A request faults when it is not word aligned or its word index falls past the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (addr[WORD_W-1:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response port between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_stall
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word-addressed storage: synchronous write, combinational read, synchronous active-low clear.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Clear wins over a write so a store committing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the pipeline's data-memory port.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              commit_s;
  logic              c_we_s;
  logic [WORD_W-1:0] c_addr_s;
  logic [WORD_W-1:0] c_wdata_s;
  logic              c_err_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_rdata_s;

  // Next-state, capture and commit logic; with LATENCY==1 the commit uses the live request.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    commit_s  = 1'b0;
    c_we_s    = we_q;
    c_addr_s  = addr_q;
    c_wdata_s = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d      = bus.req_we;
          addr_d    = bus.req_addr;
          wdata_d   = bus.req_wdata;
          c_we_s    = bus.req_we;
          c_addr_s  = bus.req_addr;
          c_wdata_s = bus.req_wdata;
          if (LATENCY == 1) begin
            commit_s = 1'b1;
            state_d  = ST_RESP;
          end else begin
            count_d = LAT_W'(LATENCY - 1);
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        count_d = count_q - LAT_W'(1);
        if (count_q == LAT_W'(1)) begin
          commit_s = 1'b1;
          state_d  = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    c_err_s  = addr_err(c_addr_s, DEPTH);
    mem_we_s = commit_s & c_we_s & ~c_err_s;
    if (commit_s) begin
      err_d   = c_err_s;
      rdata_d = (!c_err_s && !c_we_s) ? mem_rdata_s : '0;
    end else begin
      err_d   = err_q;
      rdata_d = rdata_q;
    end
  end

  // State, counter, capture and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .clr_n (rst),
    .we    (mem_we_s),
    .waddr (c_addr_s[IDX_W+1:2]),
    .wdata (c_wdata_s),
    .raddr (c_addr_s[IDX_W+1:2]),
    .rdata (mem_rdata_s)
  );

  // Handshake outputs decode the registered state only, so rsp_ready never reaches req_ready.
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_stall = (bus.req_valid & (state_q != ST_IDLE)) | (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for most cases, LATENCY=1 for back-to-back.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   cyc;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q [$];

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the LATENCY=2 instance, with optional response backpressure.
  task automatic txn0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int hold, input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    exp_t e;
    logic [31:0] first_rdata;
    bus0.req_valid = 1'b1;
    bus0.req_we    = we;
    bus0.req_addr  = addr;
    bus0.req_wdata = wdata;
    n = 0;
    while (!bus0.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    sb_q.push_back('{err: exp_err, rdata: exp_rdata});
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    bus0.req_we    = ~we;
    bus0.req_addr  = 32'h0000_0000;
    bus0.req_wdata = 32'hBAD0_BAD0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus0.rsp_valid && n < 20);
    check("latency", 32'(n), 32'd2);
    first_rdata = bus0.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      check("bp_valid", 32'(bus0.rsp_valid), 32'd1);
      check("bp_rdata", bus0.rsp_rdata, first_rdata);
      check("bp_ready", 32'(bus0.req_ready), 32'd0);
      check("bp_stall", 32'(bus0.mem_stall), 32'd1);
      @(negedge clk);
    end
    bus0.rsp_ready = 1'b1;
    e = sb_q.pop_front();
    check("rsp_rdata", bus0.rsp_rdata, e.rdata);
    check("rsp_err", 32'(bus0.rsp_err), 32'(e.err));
    @(posedge clk);
    #1;
    bus0.rsp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(bus0.rsp_valid), 32'd0);
    check("post_ready", 32'(bus0.req_ready), 32'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   acc [2];
    int   n;
    exp_t e;
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst      = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.rsp_ready = 1'b0;

    // 1. Reset
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus0.rsp_err), 32'd0);
    check("rst_stall", 32'(bus0.mem_stall), 32'd0);
    txn0(1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b0);

    // 2. Store then load
    txn0(1'b1, 32'h04, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    txn0(1'b0, 32'h04, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);

    // 3. Backpressure on a load
    txn0(1'b0, 32'h04, 32'h0, 5, 32'hDEAD_BEEF, 1'b0);

    // 4. Errors: misaligned load, out-of-range store, word 0 untouched
    txn0(1'b1, 32'h14, 32'h5555_AAAA, 0, 32'h0, 1'b0);
    txn0(1'b0, 32'h16, 32'h0, 0, 32'h0, 1'b1);
    txn0(1'b1, 32'h100, 32'hCAFE_F00D, 0, 32'h0, 1'b1);
    txn0(1'b0, 32'h00, 32'h0, 0, 32'h0, 1'b0);
    txn0(1'b0, 32'hFC, 32'h0, 0, 32'h0, 1'b0);
    txn0(1'b0, 32'h14, 32'h0, 0, 32'h5555_AAAA, 1'b0);

    // 5. Reset while a store is waiting to commit
    bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_addr = 32'h08; bus0.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check("mid_wait_stall", 32'(bus0.mem_stall), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus0.rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus0.req_ready), 32'd1);
    txn0(1'b0, 32'h08, 32'h0, 0, 32'h0, 1'b0);
    txn0(1'b0, 32'h04, 32'h0, 0, 32'h0, 1'b0);

    // 6. Back-to-back on the LATENCY=1 instance with rsp_ready held high
    txn_b2b_store: begin
      bus1.rsp_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
        bus1.req_valid = 1'b1;
        bus1.req_we    = (k == 0);
        bus1.req_addr  = 32'h0C;
        bus1.req_wdata = 32'hA5A5_5A5A;
        n = 0;
        while (!bus1.req_ready && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("b2b_accept_timeout", 32'(n < 20), 32'd1);
        acc[k] = cyc;
        sb_q.push_back('{err: 1'b0, rdata: (k == 0) ? 32'h0 : 32'hA5A5_5A5A});
        @(posedge clk);
        #1;
        bus1.req_valid = 1'b0;
        bus1.req_addr  = 32'h3C;
        @(negedge clk);
        check("b2b_latency_valid", 32'(bus1.rsp_valid), 32'd1);
        e = sb_q.pop_front();
        check("b2b_rdata", bus1.rsp_rdata, e.rdata);
        check("b2b_err", 32'(bus1.rsp_err), 32'(e.err));
        check("b2b_no_combo_ready", 32'(bus1.req_ready), 32'd0);
        @(negedge clk);
        check("b2b_idle_ready", 32'(bus1.req_ready), 32'd1);
      end
      check("b2b_spacing", 32'(acc[1] - acc[0]), 32'd2);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
